// File: rtl/score_pkg.sv
// Shared types and constants for the score/level controller.
package score_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, FLASH, ADVANCE} state_t;

   localparam int unsigned NUM_DOTS      = 32;
   localparam int unsigned FLASH_TICKS   = 8;
   localparam int unsigned LEVEL_MAX     = 15;
   localparam logic [15:0] SCORE_MAX_BCD = 16'h9990;

   function automatic logic [5:0] popcount(input logic [NUM_DOTS-1:0] v);
      logic [5:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUM_DOTS; i++) n = n + 6'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/score_ctrl_if.sv
// Game-side signal bundle of score_ctrl: frame/dot inputs, score/level/status outputs.
interface score_ctrl_if;
   import score_pkg::*;

   logic                frame_tick;
   logic                game_start;
   logic [NUM_DOTS-1:0] dots_left;
   logic [15:0]         score_bcd;
   logic [3:0]          level;
   logic                level_clear;
   logic                flash;
   logic                dots_reset;
   logic                playing;

   modport master (
      output frame_tick, game_start, dots_left,
      input  score_bcd, level, level_clear, flash, dots_reset, playing
   );

   modport slave (
      input  frame_tick, game_start, dots_left,
      output score_bcd, level, level_clear, flash, dots_reset, playing
   );

endinterface

// File: rtl/score_ctrl_bcd_inc4.sv
// Adds 10 to a four-digit BCD score (tens digit, ripple to thousands), holding at the maximum.
module bcd_inc4
   import score_pkg::*;
(
   input  logic [15:0] din,
   output logic [15:0] dout
);

   logic [3:0] tens, hund, thou;

   always_comb begin
      tens = din[7:4];
      hund = din[11:8];
      thou = din[15:12];
      dout = din;
      if (din != SCORE_MAX_BCD) begin
         if (tens != 4'd9) begin
            tens = tens + 4'd1;
         end else begin
            tens = '0;
            if (hund != 4'd9) begin
               hund = hund + 4'd1;
            end else begin
               hund = '0;
               thou = thou + 4'd1;
            end
         end
         dout = {thou, hund, tens, 4'h0};
      end
   end

endmodule

// File: rtl/score_ctrl.sv
// Score/level controller: counts eaten dots into a BCD score and sequences play, flash and level advance.
module score_ctrl
   import score_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset,
   score_ctrl_if.slave  bus
);

   state_t              state_q, state_nxt;
   logic [NUM_DOTS-1:0] prev_q;
   logic [5:0]          pending_q, pending_nxt;
   logic [2:0]          tick_q, tick_nxt;
   logic [15:0]         score_q, score_nxt, score_inc;
   logic [3:0]          level_q, level_nxt;
   logic                flash_q, flash_nxt;
   logic                level_clear_q, level_clear_nxt;
   logic                dots_reset_q, dots_reset_nxt;
   logic                playing_q, playing_nxt;
   logic [5:0]          pop;
   logic [6:0]          pend_sum;

   bcd_inc4 u_inc (.din(score_q), .dout(score_inc));

   assign pop = popcount(bus.dots_left & ~prev_q);

   always_comb begin
      state_nxt       = state_q;
      pending_nxt     = pending_q;
      tick_nxt        = tick_q;
      score_nxt       = score_q;
      level_nxt       = level_q;
      flash_nxt       = flash_q;
      level_clear_nxt = 1'b0;
      dots_reset_nxt  = 1'b0;

      pend_sum = {1'b0, pending_q} + ((state_q == PLAY) ? {1'b0, pop} : 7'd0);
      if (pend_sum != 7'd0) begin
         pending_nxt = 6'(pend_sum - 7'd1);
         score_nxt   = score_inc;
      end

      if (bus.game_start) begin
         state_nxt      = ADVANCE;
         pending_nxt    = '0;
         tick_nxt       = '0;
         score_nxt      = '0;
         level_nxt      = 4'd1;
         flash_nxt      = 1'b0;
         dots_reset_nxt = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: ;
            // Level clears only once this cycle's new dots are also scored.
            PLAY: if (bus.dots_left == '1 && pend_sum == 7'd0) begin
               state_nxt       = FLASH;
               level_clear_nxt = 1'b1;
               flash_nxt       = 1'b1;
               tick_nxt        = '0;
            end
            FLASH: if (bus.frame_tick) begin
               if (tick_q == 3'(FLASH_TICKS - 1)) begin
                  state_nxt      = ADVANCE;
                  flash_nxt      = 1'b0;
                  dots_reset_nxt = 1'b1;
                  level_nxt      = (level_q == 4'(LEVEL_MAX)) ? level_q : level_q + 4'd1;
               end else begin
                  flash_nxt = ~flash_q;
                  tick_nxt  = tick_q + 3'd1;
               end
            end
            ADVANCE: if (bus.dots_left == '0) state_nxt = PLAY;
            default: state_nxt = IDLE;
         endcase
      end

      playing_nxt = (state_nxt == PLAY);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q       <= IDLE;
         prev_q        <= '0;
         pending_q     <= '0;
         tick_q        <= '0;
         score_q       <= '0;
         level_q       <= '0;
         flash_q       <= 1'b0;
         level_clear_q <= 1'b0;
         dots_reset_q  <= 1'b0;
         playing_q     <= 1'b0;
      end else begin
         state_q       <= state_nxt;
         prev_q        <= bus.dots_left;
         pending_q     <= pending_nxt;
         tick_q        <= tick_nxt;
         score_q       <= score_nxt;
         level_q       <= level_nxt;
         flash_q       <= flash_nxt;
         level_clear_q <= level_clear_nxt;
         dots_reset_q  <= dots_reset_nxt;
         playing_q     <= playing_nxt;
      end
   end

   assign bus.score_bcd   = score_q;
   assign bus.level       = level_q;
   assign bus.flash       = flash_q;
   assign bus.level_clear = level_clear_q;
   assign bus.dots_reset  = dots_reset_q;
   assign bus.playing     = playing_q;

endmodule

// File: tb/tb_score_ctrl.sv
// Directed bench for score_ctrl with a score scoreboard fed as dots are eaten.
module tb_score_ctrl;
   import score_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [15:0] exp_q[$];
   logic [15:0] score_now;
   int          sc_tens;
   logic        exp_flash;

   score_ctrl_if bus ();

   score_ctrl dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10), 4'h0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue one expected score per eaten dot, saturating at 999 tens.
   task automatic eat(input int k);
      for (int i = 0; i < k; i++) begin
         if (sc_tens < 999) sc_tens++;
         exp_q.push_back(to_bcd(sc_tens));
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) score_now = exp_q.pop_front();
      chk("score", bus.score_bcd, score_now);
      chk("pending", dut.pending_q, exp_q.size());
   endtask

   task automatic model_clear();
      exp_q.delete();
      sc_tens   = 0;
      score_now = '0;
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.game_start = 1'b0;
      bus.dots_left  = '0;
      model_clear();

      // reset state
      #12;
      chk("rst_score", bus.score_bcd, 16'h0000);
      chk("rst_level", bus.level, 4'd0);
      chk("rst_flash", bus.flash, 1'b0);
      chk("rst_lclear", bus.level_clear, 1'b0);
      chk("rst_dreset", bus.dots_reset, 1'b0);
      chk("rst_playing", bus.playing, 1'b0);
      chk("rst_state", dut.state_q, IDLE);
      @(negedge Clk);
      Reset = 1'b1;
      step();
      chk("idle_state", dut.state_q, IDLE);

      // new game: ADVANCE then PLAY
      bus.game_start = 1'b1;
      step();
      bus.game_start = 1'b0;
      chk("start_state", dut.state_q, ADVANCE);
      chk("start_dreset", bus.dots_reset, 1'b1);
      chk("start_level", bus.level, 4'd1);
      chk("start_playing", bus.playing, 1'b0);
      step();
      chk("play_state", dut.state_q, PLAY);
      chk("play_playing", bus.playing, 1'b1);
      chk("dreset_once", bus.dots_reset, 1'b0);

      // three dots at once
      bus.dots_left = 32'h0000_0007;
      eat(3);
      repeat (3) step();
      chk("burst3_score", bus.score_bcd, 16'h0030);

      // remaining dots one per cycle
      for (int b = 3; b < 32; b++) begin
         bus.dots_left[b] = 1'b1;
         eat(1);
         step();
      end
      chk("all_score", bus.score_bcd, 16'h0320);
      chk("no_early_clear", bus.level_clear, 1'b0);
      step();
      chk("lclear", bus.level_clear, 1'b1);
      chk("flash_state", dut.state_q, FLASH);
      chk("flash_init", bus.flash, 1'b1);
      step();
      chk("lclear_once", bus.level_clear, 1'b0);
      exp_flash = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         bus.frame_tick = 1'b1;
         step();
         bus.frame_tick = 1'b0;
         exp_flash = (t == 8) ? 1'b0 : ~exp_flash;
         chk("flash_tick", bus.flash, exp_flash);
         chk("flash_dreset", bus.dots_reset, (t == 8));
         step();
         chk("flash_hold", bus.flash, exp_flash);
      end
      chk("adv_level", bus.level, 4'd2);
      chk("adv_state", dut.state_q, ADVANCE);
      step();
      chk("adv_stale", dut.state_q, ADVANCE);
      chk("adv_playing", bus.playing, 1'b0);
      bus.dots_left = '0;
      step();
      chk("lvl2_play", dut.state_q, PLAY);

      // game_start beats level clear
      bus.dots_left = '1;
      eat(32);
      repeat (32) step();
      chk("gs_score", bus.score_bcd, 16'h0640);
      bus.game_start = 1'b1;
      model_clear();
      step();
      bus.game_start = 1'b0;
      chk("gs_no_clear", bus.level_clear, 1'b0);
      chk("gs_level", bus.level, 4'd1);
      chk("gs_state", dut.state_q, ADVANCE);
      chk("gs_dreset", bus.dots_reset, 1'b1);
      bus.dots_left = '0;
      step();
      chk("gs_play", dut.state_q, PLAY);

      // drive score up to 9980, then saturate
      for (int r = 0; r < 32; r++) begin
         bus.dots_left = 32'h7FFF_FFFF;
         eat(31);
         step();
         bus.dots_left = '0;
         repeat (30) step();
      end
      for (int b = 0; b < 6; b++) begin
         bus.dots_left[b] = 1'b1;
         eat(1);
         step();
      end
      chk("pre_score", bus.score_bcd, 16'h9980);
      for (int b = 6; b < 9; b++) begin
         bus.dots_left[b] = 1'b1;
         eat(1);
         step();
      end
      repeat (3) step();
      chk("sat_score", bus.score_bcd, 16'h9990);

      // reset in the middle of FLASH
      bus.dots_left = '1;
      eat(23);
      repeat (23) step();
      step();
      chk("f2_lclear", bus.level_clear, 1'b1);
      repeat (2) begin
         bus.frame_tick = 1'b1;
         step();
         bus.frame_tick = 1'b0;
      end
      chk("f2_state", dut.state_q, FLASH);
      #3;
      Reset = 1'b0;
      #1;
      chk("ar_score", bus.score_bcd, 16'h0000);
      chk("ar_level", bus.level, 4'd0);
      chk("ar_flash", bus.flash, 1'b0);
      chk("ar_lclear", bus.level_clear, 1'b0);
      chk("ar_dreset", bus.dots_reset, 1'b0);
      chk("ar_playing", bus.playing, 1'b0);
      chk("ar_state", dut.state_q, IDLE);
      chk("ar_prev", dut.prev_q, 32'h0);
      model_clear();
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) begin
         step();
         chk("rel_state", dut.state_q, IDLE);
         chk("rel_dreset", bus.dots_reset, 1'b0);
         chk("rel_lclear", bus.level_clear, 1'b0);
         chk("rel_flash", bus.flash, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
